// File: rtl/mc14500_pkg.sv
// Shared definitions for the MC14500B core: opcode encoding, fetch FSM
// states and the instruction-word width helper.
package mc14500_pkg;

    localparam int unsigned SIZE_LOG_DEFAULT = 12;
    localparam int unsigned OPCODE_W         = 4;

    // Instruction word: 4-bit opcode on top of a SIZE_LOG-bit operand.
    function automatic int unsigned instr_w(input int unsigned size_log);
        return OPCODE_W + size_log;
    endfunction

    typedef enum logic [3:0] {
        OP_NOPO = 4'h0,
        OP_LD   = 4'h1,
        OP_LDC  = 4'h2,
        OP_AND  = 4'h3,
        OP_ANDC = 4'h4,
        OP_OR   = 4'h5,
        OP_ORC  = 4'h6,
        OP_XNOR = 4'h7,
        OP_STO  = 4'h8,
        OP_STOC = 4'h9,
        OP_IEN  = 4'hA,
        OP_OEN  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RTN  = 4'hD,
        OP_SKZ  = 4'hE,
        OP_NOPF = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_JUMP  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch for the MC14500B core: reads program memory at pc_addr
// (req/ack), presents opcode/operand downstream (valid/ready) and steers the
// program counter (pc_inc after each consumed word, pc_write on JMP).
// Optional macro FETCH_SKIP_EN: RTN, and SKZ with rr=0, discard the next word.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pc_addr                  current program counter
//   pc_inc, pc_write         counter advance / load pulses
//   pc_target                jump target, valid with pc_write
//   mem_req, mem_addr        program memory read request/address
//   mem_ack, mem_data        read data valid / instruction word
//   instr_valid, instr_ready downstream handshake
//   opcode, operand          issued instruction fields
//   rr                       result register (SKZ condition)
module instruction_fetch
    import mc14500_pkg::*;
#(
    parameter int unsigned SIZE_LOG = SIZE_LOG_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SIZE_LOG-1:0]           pc_addr,
    output logic                          pc_inc,
    output logic                          pc_write,
    output logic [SIZE_LOG-1:0]           pc_target,
    output logic                          mem_req,
    output logic [SIZE_LOG-1:0]           mem_addr,
    input  logic                          mem_ack,
    input  logic [instr_w(SIZE_LOG)-1:0]  mem_data,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [OPCODE_W-1:0]           opcode,
    output logic [SIZE_LOG-1:0]           operand,
    input  logic                          rr
);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic                  capture_instr;
    logic                  capture_jump;
    logic                  skip_pending;
    logic [OPCODE_W-1:0]   mem_op;
    logic [SIZE_LOG-1:0]   mem_opd;

    assign mem_op  = mem_data[SIZE_LOG+OPCODE_W-1:SIZE_LOG];
    assign mem_opd = mem_data[SIZE_LOG-1:0];

    // Address is a pass-through of the registered counter while requesting.
    assign mem_addr = mem_req ? pc_addr : '0;

`ifdef FETCH_SKIP_EN
    logic skip_next;

    // Skip flag: armed on accept of RTN / SKZ(rr=0), cleared by the discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_pending <= 1'b0;
        end else begin
            skip_pending <= skip_next;
        end
    end
`else
    logic unused_rr;

    assign skip_pending = 1'b0;
    assign unused_rr    = rr;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_next    = state;
        capture_instr = 1'b0;
        capture_jump  = 1'b0;
        mem_req       = 1'b0;
        instr_valid   = 1'b0;
        pc_inc        = 1'b0;
        pc_write      = 1'b0;
`ifdef FETCH_SKIP_EN
        skip_next     = skip_pending;
`endif
        case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (skip_pending) begin
                        // Discarded word: advance past it and keep fetching.
                        pc_inc = 1'b1;
`ifdef FETCH_SKIP_EN
                        skip_next = 1'b0;
`endif
                    end else if (mem_op == OP_JMP) begin
                        capture_jump = 1'b1;
                        state_next   = ST_JUMP;
                    end else begin
                        capture_instr = 1'b1;
                        state_next    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    pc_inc     = 1'b1;
                    state_next = ST_FETCH;
`ifdef FETCH_SKIP_EN
                    if ((opcode == OP_RTN) || ((opcode == OP_SKZ) && !rr)) begin
                        skip_next = 1'b1;
                    end
`endif
                end
            end
            ST_JUMP: begin
                pc_write   = 1'b1;
                state_next = ST_FETCH;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Instruction and jump-target capture on the accepted memory read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode    <= '0;
            operand   <= '0;
            pc_target <= '0;
        end else begin
            if (capture_instr) begin
                opcode  <= mem_op;
                operand <= mem_opd;
            end
            if (capture_jump) begin
                pc_target <= mem_opd;
            end
        end
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

- Consumer side of the program-counter interface for the MC14500B core.
- Reads the current program address, fetches the instruction word from program memory with a req/ack handshake, and presents a decoded opcode/operand to the execution unit with valid/ready.
- Drives the counter: an increment pulse after each consumed word, or a load of the jump target on JMP.

## Interface
- SIZE_LOG, 12, program address width; memory word is 4+SIZE_LOG bits.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_addr  in  SIZE_LOG  current program counter value (registered upstream).
- pc_inc  out  1  one-cycle pulse: advance counter by 1.
- pc_write  out  1  one-cycle pulse: load counter with pc_target.
- pc_target  out  SIZE_LOG  jump target, valid while pc_write=1.
- mem_req  out  1  memory read request.
- mem_addr  out  SIZE_LOG  read address, equals pc_addr while mem_req=1.
- mem_ack  in  1  read data valid this cycle.
- mem_data  in  4+SIZE_LOG  instruction word: opcode [SIZE_LOG+3:SIZE_LOG], operand [SIZE_LOG-1:0].
- instr_valid  out  1  opcode/operand valid.
- instr_ready  in  1  execution unit accepts.
- opcode  out  4  registered opcode.
- operand  out  SIZE_LOG  registered operand.
- rr  in  1  result register, sampled for SKZ.

## Operation
- States: IDLE, FETCH, ISSUE, JUMP.
- Reset: state IDLE; skip_pending=0; all outputs 0.
- IDLE: move to FETCH next cycle.
- FETCH:
  - mem_req=1, mem_addr=pc_addr.
  - mem_ack=0: stay in FETCH.
  - mem_ack=1 with skip_pending=1 (FETCH_SKIP_EN only): discard the word, pulse pc_inc, clear skip_pending, stay in FETCH.
  - mem_ack=1 with opcode 4'hC (JMP): capture the operand into pc_target, go to JUMP.
  - mem_ack=1 with any other opcode: capture opcode/operand, go to ISSUE.
- ISSUE:
  - instr_valid=1; opcode/operand held stable until the handshake.
  - On instr_valid&&instr_ready: pulse pc_inc, go to FETCH.
- JUMP: pc_write=1 for exactly one cycle, then FETCH. JMP is never presented downstream.
- mem_ack is ignored outside FETCH.
- 4'h0 (NOPO) and 4'hF (NOPF) are issued like any other opcode.
- Asynchronous rst at any point aborts the fetch or issue in progress:
  - state returns to IDLE;
  - skip_pending is cleared;
  - no pc_inc or pc_write is produced.

## Timing
- Zero-wait memory (ack in the first FETCH cycle): instr_valid rises 1 cycle after the FETCH cycle.
- Issued instruction: minimum 2 cycles per instruction (FETCH + ISSUE).
- JMP: 2 cycles (FETCH + JUMP).
- Skipped word: 1 cycle.
- pc_inc/pc_write pulse in the handshake cycle. The counter updates on that edge, and the next FETCH uses the new pc_addr.
- mem_data is sampled only on the edge where mem_req&&mem_ack.
- pc_inc and pc_write are never asserted together.

## Configuration
- Macro FETCH_SKIP_EN.
- Defined:
  - On the accept of 4'hD (RTN), set skip_pending.
  - On the accept of 4'hE (SKZ) with rr=0, set skip_pending.
  - The next fetched word, of any opcode including JMP, is discarded as described under FETCH.
  - RTN/SKZ are still issued downstream.
- Not defined: skip_pending is constant 0, rr is unused, and RTN/SKZ are issued like any other opcode.

## Structure
- Shared package mc14500_pkg holds:
  - opcode enum (4 bits, including OP_NOPO=0, OP_JMP=C, OP_RTN=D, OP_SKZ=E, OP_NOPF=F);
  - fetch state typedef;
  - INSTR_W=4+SIZE_LOG helper.
- Single module, no sub-module; the decode is two comparisons.

## Test plan
- Reset, then zero-wait memory with word 16'h1005 at address 0, instr_ready=1:
  - mem_req rises 1 cycle after rst deasserts;
  - opcode=1 and operand=005 are valid the next cycle;
  - pc_inc pulses once.
- Memory ack delayed 3 cycles, then instr_ready held low 2 cycles:
  - mem_req stays high 4 cycles;
  - instr_valid stays high 3 cycles with opcode/operand stable;
  - exactly one pc_inc.
- Word 16'hC2A0 (JMP):
  - pc_write pulses with pc_target=12'h2A0;
  - instr_valid never rises;
  - the next mem_addr equals the new pc_addr.
- FETCH_SKIP_EN, SKZ with rr=0, followed by JMP 16'hC100:
  - SKZ is issued, then the JMP is discarded with one pc_inc and no pc_write.
  - Repeat with rr=1: the JMP is executed.
- rst asserted during ISSUE:
  - instr_valid, mem_req, pc_inc and pc_write drop immediately;
  - after release, fetching restarts from pc_addr with no stale instruction.
